rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter_pkg.sv | 34 +++
 rtl/rf_wb_fifo.sv | 75 +++++++
 rtl/rf_wb_arbiter.sv | 134 +++++++++++++
 tb/tb_rf_wb_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// ============================================================================
// Module   : rf_wb_arbiter_pkg
// Brief    : Shared widths, write-request struct and requester select type
//            for the register-file writeback arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_sel_e;

    function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] mask;
        mask       = '0;
        mask[addr] = 1'b1;
        return mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rf_wb_fifo.sv
// ============================================================================
// Module   : rf_wb_fifo
// Brief    : In-order {addr, data} FIFO with wrap-bit pointers and per-entry
//            address/valid visibility for the pending-register mask.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_fifo
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  push,
    input  wb_req_t                               push_entry,
    input  logic                                  pop,
    output wb_req_t                               head,
    output logic                                  full,
    output logic                                  empty,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]      entry_addr,
    output logic [DEPTH-1:0]                      entry_valid
);

    localparam int                c_ptr_w   = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]  c_ptr_one = {{c_ptr_w{1'b0}}, 1'b1};

    wb_req_t              r_mem [DEPTH];
    logic [c_ptr_w:0]     r_wptr;
    logic [c_ptr_w:0]     r_rptr;
    logic [c_ptr_w:0]     w_count;
    logic                 w_push_ok;
    logic                 w_pop_ok;

    assign empty     = (r_wptr == r_rptr);
    assign full      = (r_wptr[c_ptr_w] != r_rptr[c_ptr_w]) &&
                       (r_wptr[c_ptr_w-1:0] == r_rptr[c_ptr_w-1:0]);
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign w_count   = r_wptr - r_rptr;
    assign head      = r_mem[r_rptr[c_ptr_w-1:0]];

    // Storage carries no reset; only the pointers define what is live.
    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wptr[c_ptr_w-1:0]] <= push_entry;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
        end
    end

    // A slot is live when its distance from the read pointer is below the fill count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [c_ptr_w-1:0] w_offset;
        assign w_offset        = c_ptr_w'(gi) - r_rptr[c_ptr_w-1:0];
        assign entry_valid[gi] = ({1'b0, w_offset} < w_count);
        assign entry_addr[gi]  = r_mem[gi].addr;
    end

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// Module   : rf_wb_arbiter
// Brief    : Two-requester round-robin register-file writeback arbiter with
//            per-requester FIFOs, registered write port and pending mask.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req0_valid_i,
    input  logic [REG_ADDR_W-1:0]  req0_addr_i,
    input  logic [REG_DATA_W-1:0]  req0_data_i,
    output logic                   req0_ready_o,
    input  logic                   req1_valid_i,
    input  logic [REG_ADDR_W-1:0]  req1_addr_i,
    input  logic [REG_DATA_W-1:0]  req1_data_i,
    output logic                   req1_ready_o,
    output logic                   RegWrite_o,
    output logic [REG_ADDR_W-1:0]  RDaddr_o,
    output logic [REG_DATA_W-1:0]  RDdata_o,
    output logic [NUM_REGS-1:0]    pending_o
);

    wb_req_t                                w_head0;
    wb_req_t                                w_head1;
    wb_req_t                                w_head;
    logic                                   w_full0;
    logic                                   w_full1;
    logic                                   w_empty0;
    logic                                   w_empty1;
    logic                                   w_pop0;
    logic                                   w_pop1;
    logic                                   w_grant;
    req_sel_e                               w_sel;
    logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0]  w_addr0;
    logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0]  w_addr1;
    logic [FIFO_DEPTH-1:0]                  w_valid0;
    logic [FIFO_DEPTH-1:0]                  w_valid1;
    logic [NUM_REGS-1:0]                    w_pending;

    req_sel_e                               r_prio;
    logic                                   r_regwrite;
    logic [REG_ADDR_W-1:0]                  r_rdaddr;
    logic [REG_DATA_W-1:0]                  r_rddata;

    rf_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push        (req0_valid_i),
        .push_entry  ('{addr: req0_addr_i, data: req0_data_i}),
        .pop         (w_pop0),
        .head        (w_head0),
        .full        (w_full0),
        .empty       (w_empty0),
        .entry_addr  (w_addr0),
        .entry_valid (w_valid0)
    );

    rf_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push        (req1_valid_i),
        .push_entry  ('{addr: req1_addr_i, data: req1_data_i}),
        .pop         (w_pop1),
        .head        (w_head1),
        .full        (w_full1),
        .empty       (w_empty1),
        .entry_addr  (w_addr1),
        .entry_valid (w_valid1)
    );

    assign req0_ready_o = !w_full0;
    assign req1_ready_o = !w_full1;

    always_comb begin
        w_grant = !w_empty0 || !w_empty1;
        w_sel   = REQ0;
        if (!w_empty0 && !w_empty1) begin
            w_sel = r_prio;
        end else if (!w_empty1) begin
            w_sel = REQ1;
        end
        w_pop0 = w_grant && (w_sel == REQ0);
        w_pop1 = w_grant && (w_sel == REQ1);
        w_head = (w_sel == REQ1) ? w_head1 : w_head0;
    end

    // Register 0 is hardwired, so its entries drain without a write strobe.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_prio     <= REQ0;
            r_regwrite <= 1'b0;
            r_rdaddr   <= '0;
            r_rddata   <= '0;
        end else begin
            r_regwrite <= w_grant && (w_head.addr != '0);
            if (w_grant) begin
                r_prio   <= (w_sel == REQ0) ? REQ1 : REQ0;
                r_rdaddr <= w_head.addr;
                r_rddata <= w_head.data;
            end
        end
    end

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_valid0[i]) begin
                w_pending = w_pending | addr_onehot(w_addr0[i]);
            end
            if (w_valid1[i]) begin
                w_pending = w_pending | addr_onehot(w_addr1[i]);
            end
        end
        if (r_regwrite) begin
            w_pending = w_pending | addr_onehot(r_rdaddr);
        end
        w_pending[0] = 1'b0;
    end

    assign RegWrite_o = r_regwrite;
    assign RDaddr_o   = r_rdaddr;
    assign RDdata_o   = r_rddata;
    assign pending_o  = w_pending;

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// ============================================================================
// Module   : tb_rf_wb_arbiter
// Brief    : Scoreboard bench for rf_wb_arbiter: directed streams, ordering,
//            backpressure, zero register, same-address and mid-stream reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    localparam int FIFO_DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req0_valid_i;
    logic [4:0]  req0_addr_i;
    logic [31:0] req0_data_i;
    logic        req0_ready_o;
    logic        req1_valid_i;
    logic [4:0]  req1_addr_i;
    logic [31:0] req1_data_i;
    logic        req1_ready_o;
    logic        RegWrite_o;
    logic [4:0]  RDaddr_o;
    logic [31:0] RDdata_o;
    logic [31:0] pending_o;

    rf_wb_arbiter #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req0_valid_i (req0_valid_i),
        .req0_addr_i  (req0_addr_i),
        .req0_data_i  (req0_data_i),
        .req0_ready_o (req0_ready_o),
        .req1_valid_i (req1_valid_i),
        .req1_addr_i  (req1_addr_i),
        .req1_data_i  (req1_data_i),
        .req1_ready_o (req1_ready_o),
        .RegWrite_o   (RegWrite_o),
        .RDaddr_o     (RDaddr_o),
        .RDdata_o     (RDdata_o),
        .pending_o    (pending_o)
    );

    always #5 clk_i = ~clk_i;

    int      checks = 0;
    int      errors = 0;
    wb_req_t exp_q[$];
    wb_req_t mon_e;

    wb_req_t s0[8];
    wb_req_t s1[8];
    int      n0;
    int      n1;
    int      acc1[8];
    logic    rdy1_h[64];
    int      bp_cycles;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Every observed write must match the head of the expected queue.
    always @(negedge clk_i) begin
        if (rst_i && RegWrite_o) begin
            check_val("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check_val("wr_addr", 32'(RDaddr_o), 32'(mon_e.addr));
                check_val("wr_data", RDdata_o, mon_e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        exp_q.delete();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check_val(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Offers s0/s1 lists on both requesters, advancing each only on a handshake.
    task automatic run_streams();
        int   i0 = 0;
        int   i1 = 0;
        int   cyc = 0;
        logic a0;
        logic a1;
        bp_cycles = 0;
        while ((i0 < n0 || i1 < n1) && cyc < 64) begin
            req0_valid_i = (i0 < n0);
            req1_valid_i = (i1 < n1);
            if (i0 < n0) begin
                req0_addr_i = s0[i0].addr;
                req0_data_i = s0[i0].data;
            end
            if (i1 < n1) begin
                req1_addr_i = s1[i1].addr;
                req1_data_i = s1[i1].data;
            end
            rdy1_h[cyc] = req1_ready_o;
            if (!req0_ready_o || !req1_ready_o) bp_cycles++;
            a0 = req0_valid_i && req0_ready_o;
            a1 = req1_valid_i && req1_ready_o;
            tick();
            if (a0) i0++;
            if (a1) begin
                acc1[i1] = cyc;
                i1++;
            end
            cyc++;
        end
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        check_val("stream_done", 32'(i0 + i1), 32'(n0 + n1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_i        = 1'b0;
        req0_valid_i = 1'b0;
        req0_addr_i  = '0;
        req0_data_i  = '0;
        req1_valid_i = 1'b0;
        req1_addr_i  = '0;
        req1_data_i  = '0;
        #2;
        check_val("rst_regwrite", 32'(RegWrite_o), 32'd0);
        check_val("rst_rdaddr", 32'(RDaddr_o), 32'd0);
        check_val("rst_rddata", RDdata_o, 32'd0);
        check_val("rst_pending", pending_o, 32'd0);
        check_val("rst_ready0", 32'(req0_ready_o), 32'd1);
        check_val("rst_ready1", 32'(req1_ready_o), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();

        // Single write: visible on the port two edges after the push.
        req0_valid_i = 1'b1;
        req0_addr_i  = 5'd3;
        req0_data_i  = 32'h0000_00AA;
        exp_q.push_back('{addr: 5'd3, data: 32'h0000_00AA});
        tick();
        req0_valid_i = 1'b0;
        check_val("single_no_early_wr", 32'(RegWrite_o), 32'd0);
        check_val("single_pend_fifo", 32'(pending_o[3]), 32'd1);
        tick();
        check_val("single_wr_lat", 32'(RegWrite_o), 32'd1);
        check_val("single_pend_out", 32'(pending_o[3]), 32'd1);
        tick();
        check_val("single_wr_end", 32'(RegWrite_o), 32'd0);
        check_val("single_pend_clr", pending_o, 32'd0);
        drain("single_drain");

        // Contention: strict alternation starting at requester 0.
        do_reset();
        n0 = 4;
        n1 = 4;
        for (int i = 0; i < 4; i++) begin
            s0[i] = '{addr: 5'(1 + i), data: 32'h0000_0100 + 32'(i + 1)};
            s1[i] = '{addr: 5'(5 + i), data: 32'h0000_0200 + 32'(i + 5)};
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(s0[i]);
            exp_q.push_back(s1[i]);
        end
        run_streams();
        check_val("cont_backpressure", 32'(bp_cycles != 0), 32'd1);
        drain("cont_drain");

        // Full: third req1 push waits for ready to return.
        do_reset();
        n0 = 4;
        n1 = 3;
        for (int i = 0; i < 4; i++) begin
            s0[i] = '{addr: 5'(10 + i), data: 32'h0000_00A0 + 32'(i)};
        end
        for (int i = 0; i < 3; i++) begin
            s1[i] = '{addr: 5'(20 + i), data: 32'h0000_00B0 + 32'(i)};
        end
        exp_q.push_back(s0[0]);
        exp_q.push_back(s1[0]);
        exp_q.push_back(s0[1]);
        exp_q.push_back(s1[1]);
        exp_q.push_back(s0[2]);
        exp_q.push_back(s1[2]);
        exp_q.push_back(s0[3]);
        run_streams();
        check_val("full_rdy1_low", 32'(rdy1_h[2]), 32'd0);
        check_val("full_rdy1_back", 32'(rdy1_h[3]), 32'd1);
        check_val("full_b1_accept_cyc", 32'(acc1[1]), 32'd1);
        check_val("full_b2_accept_cyc", 32'(acc1[2]), 32'd3);
        drain("full_drain");

        // Zero register: popped and presented, never strobed.
        req0_valid_i = 1'b1;
        req0_addr_i  = 5'd0;
        req0_data_i  = 32'hFFFF_FFFF;
        tick();
        req0_valid_i = 1'b0;
        check_val("zero_pend_fifo", pending_o, 32'd0);
        tick();
        check_val("zero_no_wr", 32'(RegWrite_o), 32'd0);
        check_val("zero_pend_out", pending_o, 32'd0);
        check_val("zero_rdaddr", 32'(RDaddr_o), 32'd0);
        check_val("zero_rddata", RDdata_o, 32'hFFFF_FFFF);
        tick();
        check_val("zero_no_wr_late", 32'(RegWrite_o), 32'd0);
        drain("zero_drain");

        // Same address from both requesters in one cycle.
        do_reset();
        req0_valid_i = 1'b1;
        req0_addr_i  = 5'd9;
        req0_data_i  = 32'h0000_0011;
        req1_valid_i = 1'b1;
        req1_addr_i  = 5'd9;
        req1_data_i  = 32'h0000_0022;
        exp_q.push_back('{addr: 5'd9, data: 32'h0000_0011});
        exp_q.push_back('{addr: 5'd9, data: 32'h0000_0022});
        tick();
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        check_val("same_pend_buf", 32'(pending_o[9]), 32'd1);
        tick();
        check_val("same_pend_first", 32'(pending_o[9]), 32'd1);
        tick();
        check_val("same_pend_second", 32'(pending_o[9]), 32'd1);
        tick();
        check_val("same_pend_clr", pending_o, 32'd0);
        drain("same_drain");

        // Reset mid-stream with entries buffered and one in the output stage.
        do_reset();
        req0_valid_i = 1'b1;
        req0_addr_i  = 5'd14;
        req0_data_i  = 32'h0000_00C0;
        req1_valid_i = 1'b1;
        req1_addr_i  = 5'd15;
        req1_data_i  = 32'h0000_00C1;
        tick();
        req0_addr_i  = 5'd16;
        req0_data_i  = 32'h0000_00C2;
        req1_addr_i  = 5'd17;
        req1_data_i  = 32'h0000_00C3;
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        check_val("mid_rst_regwrite", 32'(RegWrite_o), 32'd0);
        check_val("mid_rst_rdaddr", 32'(RDaddr_o), 32'd0);
        check_val("mid_rst_rddata", RDdata_o, 32'd0);
        check_val("mid_rst_pending", pending_o, 32'd0);
        check_val("mid_rst_ready0", 32'(req0_ready_o), 32'd1);
        check_val("mid_rst_ready1", 32'(req1_ready_o), 32'd1);
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        @(negedge clk_i);
        tick();
        rst_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val("post_rst_no_wr", 32'(RegWrite_o), 32'd0);
            check_val("post_rst_pending", pending_o, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
